// File: rtl/usb_tx_pkt.sv
// usb_tx_pkt: USB transmit packet formatter.
// Serialises the PID byte, an optional payload and its CRC16 LSB-first,
// handing one bit to the line driver per ll_ack and flagging the final bit.
module usb_tx_pkt (
   input  logic       clk,
   input  logic       rst,
   input  logic       pkt_start,
   output logic       pkt_done,
   input  logic [3:0] pkt_pid,
   input  logic [9:0] pkt_len,
   input  logic [7:0] pkt_data,
   output logic       pkt_data_ack,
   output logic       ll_start,
   output logic       ll_bit,
   output logic       ll_last,
   input  logic       ll_ack
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PID  = 2'd1,
      DATA = 2'd2,
      CRC  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [7:0]  shreg;
   logic [2:0]  bit_cnt;
   logic [9:0]  byte_cnt;
   logic [15:0] crc;
   logic        is_data;
   logic        crc_hi;

   logic        byte_end;
   logic        have_bytes;
   logic        fb;
   logic [15:0] crc_nxt;
   logic [15:0] crc_sel;

   // Shared decode: end of byte, payload bytes still owed, next CRC value
   always_comb begin
      byte_end   = ll_ack && (bit_cnt == 3'd7);
      have_bytes = (byte_cnt != 10'd0);
      fb         = crc[0] ^ shreg[0];
      crc_nxt    = {1'b0, crc[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
      crc_sel    = (state == DATA) ? crc_nxt : crc;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: packet class and remaining byte count steer the walk
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pkt_start) begin
               state_nxt = PID;
            end
         end
         PID: begin
            if (byte_end) begin
               if (!is_data) begin
                  state_nxt = IDLE;
               end else if (have_bytes) begin
                  state_nxt = DATA;
               end else begin
                  state_nxt = CRC;
               end
            end
         end
         DATA: begin
            if (byte_end && !have_bytes) begin
               state_nxt = CRC;
            end
         end
         CRC: begin
            if (byte_end && crc_hi) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: current bit, last-bit flag and the payload consume strobe
   always_comb begin
      ll_bit       = shreg[0];
      ll_last      = (bit_cnt == 3'd7) &&
                     (((state == PID) && !is_data) || ((state == CRC) && crc_hi));
      pkt_data_ack = byte_end && have_bytes &&
                     (((state == PID) && is_data) || (state == DATA));
   end

   // Datapath: shift register, counters, CRC and the registered pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg    <= 8'h00;
         bit_cnt  <= 3'd0;
         byte_cnt <= 10'd0;
         crc      <= 16'hFFFF;
         is_data  <= 1'b0;
         crc_hi   <= 1'b0;
         ll_start <= 1'b0;
         pkt_done <= 1'b0;
      end else begin
         ll_start <= (state == IDLE) && pkt_start;
         pkt_done <= ll_ack && ll_last;
         if (state == IDLE) begin
            if (pkt_start) begin
               shreg    <= {~pkt_pid, pkt_pid};
               bit_cnt  <= 3'd0;
               is_data  <= (pkt_pid[1:0] == 2'b11);
               byte_cnt <= (pkt_pid[1:0] == 2'b11) ? pkt_len : 10'd0;
               crc      <= 16'hFFFF;
               crc_hi   <= 1'b0;
            end
         end else if (ll_ack) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (state == DATA) begin
               crc <= crc_nxt;
            end
            if (bit_cnt == 3'd7) begin
               if (pkt_data_ack) begin
                  shreg    <= pkt_data;
                  byte_cnt <= byte_cnt - 10'd1;
               end else if (state == CRC) begin
                  shreg  <= ~crc[15:8];
                  crc_hi <= 1'b1;
               end else begin
                  shreg <= ~crc_sel[7:0];
               end
            end else begin
               shreg <= {1'b0, shreg[7:1]};
            end
         end
      end
   end

endmodule

// File: tb/tb_usb_tx_pkt.sv
// tb_usb_tx_pkt: directed bench for the USB transmit packet formatter.
module tb_usb_tx_pkt;

   logic       clk = 1'b0;
   logic       rst;
   logic       pkt_start;
   logic       pkt_done;
   logic [3:0] pkt_pid;
   logic [9:0] pkt_len;
   logic [7:0] pkt_data;
   logic       pkt_data_ack;
   logic       ll_start;
   logic       ll_bit;
   logic       ll_last;
   logic       ll_ack;

   int total_checks = 0;
   int passed_checks = 0;

   logic [7:0] got_bytes [0:15];
   logic [7:0] exp_bytes [0:15];
   int start_seen, done_seen, dack_seen, last_cnt, last_pos, nbits;

   logic       up_armed = 1'b0;
   logic [7:0] up_idx;

   usb_tx_pkt dut (
      .clk          (clk),
      .rst          (rst),
      .pkt_start    (pkt_start),
      .pkt_done     (pkt_done),
      .pkt_pid      (pkt_pid),
      .pkt_len      (pkt_len),
      .pkt_data     (pkt_data),
      .pkt_data_ack (pkt_data_ack),
      .ll_start     (ll_start),
      .ll_bit       (ll_bit),
      .ll_last      (ll_last),
      .ll_ack       (ll_ack)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Upstream buffer model: prefetches byte 0x31 on start, then advances one byte per consume
   always @(posedge clk) begin
      if (pkt_start && up_armed) begin
         up_idx   <= 8'd0;
         pkt_data <= 8'h31;
      end else if (pkt_data_ack) begin
         up_idx   <= up_idx + 8'd1;
         pkt_data <= 8'h31 + up_idx + 8'd1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_checks++;
      if (got === exp) begin
         passed_checks++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (pkt_done === 1'b1) done_seen++;
      if (ll_start === 1'b1) start_seen++;
   endtask

   // Drives one packet from the current negedge; optionally injects a stray start or a reset
   task automatic applyStimulus(input logic [3:0] pid, input int len, input int gap,
                                input int disturb_at, input int reset_at);
      bit finished;
      start_seen = 0; done_seen = 0; dack_seen = 0;
      last_cnt = 0; last_pos = -1; nbits = 0;
      for (int k = 0; k < 16; k++) got_bytes[k] = 8'h00;
      pkt_pid = pid; pkt_len = len[9:0]; pkt_start = 1'b1; up_armed = 1'b1;
      tick();
      pkt_start = 1'b0; up_armed = 1'b0; pkt_pid = 4'h0; pkt_len = 10'd0;
      checkOutput("ll_start_t1", {31'd0, ll_start}, 32'd1);
      finished = 1'b0;
      for (int i = 0; i < 200 && !finished; i++) begin
         repeat (gap - 1) tick();
         if (i == reset_at) begin
            rst = 1'b1;
            #1;
            checkOutput("rst_ll_bit", {31'd0, ll_bit}, 32'd0);
            checkOutput("rst_ll_last", {31'd0, ll_last}, 32'd0);
            checkOutput("rst_ll_start", {31'd0, ll_start}, 32'd0);
            checkOutput("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
            checkOutput("rst_data_ack", {31'd0, pkt_data_ack}, 32'd0);
            tick();
            rst = 1'b0;
            tick();
            checkOutput("rst_no_done", done_seen, 32'd0);
            return;
         end
         if (i == disturb_at) begin
            pkt_start = 1'b1; pkt_pid = 4'h2; pkt_len = 10'd5;
         end
         got_bytes[i / 8][i % 8] = ll_bit;
         if (ll_last === 1'b1) begin
            last_cnt++;
            last_pos = i;
         end
         ll_ack = 1'b1;
         #1;
         if (pkt_data_ack === 1'b1) dack_seen++;
         tick();
         ll_ack = 1'b0; pkt_start = 1'b0; pkt_pid = 4'h0; pkt_len = 10'd0;
         nbits = i + 1;
         if (last_pos >= 0) finished = 1'b1;
      end
      checkOutput("pkt_done_u1", {31'd0, pkt_done}, 32'd1);
   endtask

   task automatic verifyPacket(input string name, input int nbytes, input int exp_dacks);
      checkOutput({name, "_bits"}, nbits, nbytes * 8);
      for (int j = 0; j < nbytes; j++) begin
         checkOutput({name, "_byte"}, {24'd0, got_bytes[j]}, {24'd0, exp_bytes[j]});
      end
      checkOutput({name, "_last_cnt"}, last_cnt, 32'd1);
      checkOutput({name, "_last_pos"}, last_pos, nbytes * 8 - 1);
      checkOutput({name, "_data_acks"}, dack_seen, exp_dacks);
      checkOutput({name, "_starts"}, start_seen, 32'd1);
      checkOutput({name, "_dones"}, done_seen, 32'd1);
   endtask

   task automatic setCrcVector();
      exp_bytes[0] = 8'hC3;
      for (int j = 1; j <= 9; j++) exp_bytes[j] = 8'h30 + j[7:0];
      exp_bytes[10] = 8'hC8;
      exp_bytes[11] = 8'hB4;
   endtask

   initial begin
      rst = 1'b1; pkt_start = 1'b0; pkt_pid = 4'h0; pkt_len = 10'd0; ll_ack = 1'b0;
      #1;
      checkOutput("reset_ll_start", {31'd0, ll_start}, 32'd0);
      checkOutput("reset_ll_bit", {31'd0, ll_bit}, 32'd0);
      checkOutput("reset_ll_last", {31'd0, ll_last}, 32'd0);
      checkOutput("reset_pkt_done", {31'd0, pkt_done}, 32'd0);
      checkOutput("reset_data_ack", {31'd0, pkt_data_ack}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // ACK handshake
      exp_bytes[0] = 8'hD2;
      applyStimulus(4'h2, 0, 4, -1, -1);
      verifyPacket("ack", 1, 0);
      repeat (3) @(negedge clk);

      // Zero-length DATA1
      exp_bytes[0] = 8'h4B; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'h00;
      applyStimulus(4'hB, 0, 3, -1, -1);
      verifyPacket("zlp", 3, 0);
      repeat (3) @(negedge clk);

      // CRC check vector
      setCrcVector();
      applyStimulus(4'h3, 9, 3, -1, -1);
      verifyPacket("crc9", 12, 9);
      repeat (3) @(negedge clk);

      // Acks while idle must do nothing
      start_seen = 0; done_seen = 0;
      for (int i = 0; i < 3; i++) begin
         ll_ack = 1'b1;
         tick();
         ll_ack = 1'b0;
         tick();
      end
      checkOutput("idle_ack_dones", done_seen, 32'd0);
      checkOutput("idle_ack_starts", start_seen, 32'd0);

      // Start while busy, mid-payload
      setCrcVector();
      applyStimulus(4'h3, 9, 2, 30, -1);
      verifyPacket("busy", 12, 9);
      repeat (3) @(negedge clk);

      // Reset mid-packet, then a clean packet
      applyStimulus(4'h3, 9, 2, -1, 20);
      repeat (2) @(negedge clk);
      setCrcVector();
      applyStimulus(4'h3, 9, 2, -1, -1);
      verifyPacket("post_rst", 12, 9);
      repeat (3) @(negedge clk);

      // Back-to-back: second start in the cycle after pkt_done
      exp_bytes[0] = 8'hD2;
      applyStimulus(4'h2, 0, 2, -1, -1);
      verifyPacket("b2b_ack", 1, 0);
      setCrcVector();
      applyStimulus(4'h3, 9, 2, -1, -1);
      verifyPacket("b2b_data", 12, 9);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule

// File: doc/usb_tx_pkt.md
# usb_tx_pkt

Transmit packet formatter. It sits between the transaction micro-code engine, which drives `pkt_start`, `pkt_pid`, `pkt_len` and reads EP buffer bytes through `pkt_data_ack`, and the low-level line driver, which sends SYNC, bit-stuffs, NRZI-encodes and sends EOP. The block serialises the PID byte, the payload and CRC16 LSB-first, one bit per `ll_ack`. It flags the final bit and reports completion with `pkt_done`.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `pkt_start`  in  1  one-cycle pulse that begins a packet. `pkt_pid` and `pkt_len` are valid in the same cycle.
- `pkt_done`  out  1  one-cycle pulse when the last bit has been accepted by the line driver.
- `pkt_pid`  in  4  PID to send.
- `pkt_len`  in  10  payload length in bytes, 0..1023. Used only for data PIDs.
- `pkt_data`  in  8  payload byte. Valid from the cycle after `pkt_start` or after a `pkt_data_ack` pulse.
- `pkt_data_ack`  out  1  one-cycle pulse: the current `pkt_data` byte is consumed and the upstream block advances.
- `ll_start`  out  1  one-cycle pulse that requests the line driver to start (SYNC).
- `ll_bit`  out  1  current bit to send.
- `ll_last`  out  1  `ll_bit` is the final bit of the packet.
- `ll_ack`  in  1  one-cycle pulse: the line driver took `ll_bit`. Pulses are at least 2 cycles apart.

## Operation
- **Packet classes**, decided on `pkt_pid[1:0]`:
  - `2'b11` is a data packet (DATA0/1/2, MDATA): PID, then `pkt_len` bytes, then 2 CRC bytes.
  - Every other value is PID only.
- **PID byte:** `{~pkt_pid, pkt_pid}`, sent LSB first.
- **State machine:** IDLE → PID → DATA → CRC → IDLE.
  - PID-only packets go PID → IDLE.
  - Data packets with `pkt_len`=0 go PID → CRC.
- **Shift path:** an 8-bit shift register feeds `ll_bit` = `shreg[0]`, with a 3-bit bit counter and a 10-bit byte counter.
  - Each `ll_ack` shifts the register right and increments the bit counter.
  - On the `ll_ack` of bit 7, the next byte is loaded:
    - In PID or DATA with bytes remaining: load `pkt_data` and pulse `pkt_data_ack` in that same cycle.
    - After the last payload byte: load `~crc[7:0]`, then `~crc[15:8]`.
- **Upstream data contract:** the first payload byte is already valid the cycle after `pkt_start`, because upstream prefetches on start. Therefore:
  - `pkt_data_ack` is pulsed only when a payload byte is loaded.
  - It is not pulsed on `pkt_start`.
  - The total count of `pkt_data_ack` pulses per packet equals `pkt_len`.
- **CRC16:**
  - Reflected form, polynomial 0xA001 (x^16+x^15+x^2+1), 16-bit register.
  - Initialised to 0xFFFF on `pkt_start`.
  - Updated on each `ll_ack` of a payload bit: `fb = crc[0]^ll_bit`, `crc = (crc>>1) ^ (fb ? 0xA001 : 0)`.
  - Transmitted complemented, LSB first. A zero-length payload therefore sends CRC bytes 0x00 0x00.
- **`ll_last`:** high while `ll_bit` is bit 7 of the PID byte (PID-only packets) or bit 7 of the high CRC byte (data packets).
- **`pkt_start` while not IDLE:** ignored. The packet in progress is not disturbed.
- **`ll_ack` in IDLE:** ignored. No state change, no `pkt_done`.
- **Reset:** returns to IDLE from any state, mid-packet included; the packet in flight is abandoned with no `pkt_done`. Reset values:
  - `ll_start`, `ll_last`, `pkt_done`, `pkt_data_ack` = 0.
  - `ll_bit` = 0.
  - Shift register = 0, counters = 0, CRC = 0xFFFF.

## Timing
- **`pkt_start` in cycle T:**
  - `ll_start` = 1 in T+1.
  - The shift register holds the PID byte from T+1; `ll_bit`/`ll_last` are valid from T+1.
- **`ll_bit` stability:** `ll_bit` is stable from the cycle after the previous `ll_ack` (or from T+1) until and including the cycle of the next `ll_ack`.
- **Byte loads:** a load and its `pkt_data_ack` occur in the cycle of the bit-7 `ll_ack`; the new bit 0 appears the next cycle.
  - Upstream presents the following byte one cycle after `pkt_data_ack`.
  - That byte is sampled 8 acks later, which is always at least 16 cycles.
- **End of packet:** on the `ll_ack` of the `ll_last` bit in cycle U, `pkt_done` = 1 in U+1 and state = IDLE in U+1. A new `pkt_start` is accepted in U+1.
- **Latency:** every `ll_ack` is accounted for; no bubble cycles between bytes.

## Test plan
- **ACK handshake:** `pkt_pid`=0x2 (ACK), `ll_ack` every 4 cycles → `ll_start` one cycle after start; bits 0,1,0,0,1,0,1,1 (0xD2); `ll_last` on the 8th bit only; `pkt_done` one cycle after the 8th ack; zero `pkt_data_ack` pulses.
- **Zero-length DATA1:** `pkt_pid`=0xB, `pkt_len`=0 → bytes 0x4B, 0x00, 0x00 LSB-first; 24 acks; `ll_last` on bit 24; no `pkt_data_ack`.
- **CRC check vector:** DATA0 (`pkt_pid`=0x3), `pkt_len`=9, upstream model with one-cycle read latency supplying 0x31..0x39 → bytes 0xC3, 0x31..0x39, 0xC8, 0xB4; exactly 9 `pkt_data_ack` pulses; `pkt_done` after 96 acks.
- **Start while busy:** a second `pkt_start` with a different PID mid-payload, and `ll_ack` pulses in IDLE → output bit stream identical to the undisturbed run; no extra `ll_start` or `pkt_done`.
- **Reset mid-packet:** `rst` pulse during DATA → all outputs 0 immediately; the next `pkt_start` sends a clean packet with CRC reinitialised to 0xFFFF (verified with the 9-byte vector).
- **Back-to-back packets:** `pkt_start` in the cycle after `pkt_done`, minimum `ll_ack` spacing of 2 → both packets correct, no dropped or duplicated bits.
